// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline hazard controller for the 5-stage core. It compares the operand
// needs of the D-stage instruction (Tuse) against the in-flight E/M producers
// (Tnew) and against the multi-cycle mult/div unit. On a stall, the PC and
// the D register hold, and a bubble is cleared into E.
// It also owns the mult/div busy sequencer, which is a two-state FSM plus a
// 4-bit down counter.
// Optional feature: define HSC_STALL_CNT_EN to build the 32-bit stall cycle
// counter. Without it, Stall_Cnt is tied to zero.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  D_RS_Addr,
    input  logic [4:0]  D_RT_Addr,
    input  logic [1:0]  D_Tuse_RS,
    input  logic [1:0]  D_Tuse_RT,
    input  logic        D_MD_Use,
    input  logic [1:0]  E_Tnew,
    input  logic        E_Reg_WE,
    input  logic [4:0]  E_Reg_WA,
    input  logic [1:0]  M_Tnew,
    input  logic        M_Reg_WE,
    input  logic [4:0]  M_Reg_WA,
    input  logic        E_MD_Start,
    input  logic        E_MD_Div,
    output logic        PC_WE,
    output logic        D_WE,
    output logic        E_Clr,
    output logic        MD_Busy,
    output logic [31:0] Stall_Cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_t  state_q;
    md_state_t  state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic haz_e_rs;
    logic haz_e_rt;
    logic haz_m_rs;
    logic haz_m_rt;
    logic md_busy_raw;
    logic stall;

    // Register $0 never creates a dependency.
    // A Tuse equal to Tnew is resolved by forwarding, so only a strictly
    // smaller Tuse stalls.
    assign haz_e_rs = E_Reg_WE & (E_Reg_WA == D_RS_Addr) & (D_RS_Addr != 5'd0) & (D_Tuse_RS < E_Tnew);
    assign haz_e_rt = E_Reg_WE & (E_Reg_WA == D_RT_Addr) & (D_RT_Addr != 5'd0) & (D_Tuse_RT < E_Tnew);
    assign haz_m_rs = M_Reg_WE & (M_Reg_WA == D_RS_Addr) & (D_RS_Addr != 5'd0) & (D_Tuse_RS < M_Tnew);
    assign haz_m_rt = M_Reg_WE & (M_Reg_WA == D_RT_Addr) & (D_RT_Addr != 5'd0) & (D_Tuse_RT < M_Tnew);

    // The unit counts as busy in the launch cycle itself. That way a
    // back-to-back HI/LO access right behind the start is also held.
    assign md_busy_raw = E_MD_Start | (state_q == BUSY);
    assign stall       = haz_e_rs | haz_e_rt | haz_m_rs | haz_m_rt | (D_MD_Use & md_busy_raw);

    // While reset is held, the pipeline is frozen with a bubble in E.
    assign MD_Busy = rst_n & md_busy_raw;
    assign PC_WE   = rst_n & ~stall;
    assign D_WE    = rst_n & ~stall;
    assign E_Clr   = ~rst_n | stall;

    // Mult/div sequencer state register. Reset aborts any running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load on start, count down while busy, and return to
    // IDLE after the last busy cycle. A start seen while busy reloads.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (E_MD_Start) begin
            state_d = BUSY;
            cnt_d   = E_MD_Div ? DIV_LOAD : MULT_LOAD;
        end else if (state_q == BUSY) begin
            if (cnt_q <= 4'd1) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

`ifdef HSC_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts every clock edge on which the pipeline is stalled. The count
    // wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`else
    assign Stall_Cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed scenarios followed by randomized traffic. All stimulus is checked
// against a behavioural model of the hazard rules and of the mult/div busy
// window. The model tracks the busy window as a count of remaining busy
// cycles.
// Define HSC_STALL_CNT_EN to also check the stall counter values.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  D_RS_Addr;
    logic [4:0]  D_RT_Addr;
    logic [1:0]  D_Tuse_RS;
    logic [1:0]  D_Tuse_RT;
    logic        D_MD_Use;
    logic [1:0]  E_Tnew;
    logic        E_Reg_WE;
    logic [4:0]  E_Reg_WA;
    logic [1:0]  M_Tnew;
    logic        M_Reg_WE;
    logic [4:0]  M_Reg_WA;
    logic        E_MD_Start;
    logic        E_MD_Div;
    logic        PC_WE;
    logic        D_WE;
    logic        E_Clr;
    logic        MD_Busy;
    logic [31:0] Stall_Cnt;

    int compareCount = 0;
    int failCount    = 0;

    int          mdRemaining = 0;
    logic [31:0] stallTotal  = 32'd0;
    logic        lastStall;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_RS_Addr(D_RS_Addr), .D_RT_Addr(D_RT_Addr),
        .D_Tuse_RS(D_Tuse_RS), .D_Tuse_RT(D_Tuse_RT), .D_MD_Use(D_MD_Use),
        .E_Tnew(E_Tnew), .E_Reg_WE(E_Reg_WE), .E_Reg_WA(E_Reg_WA),
        .M_Tnew(M_Tnew), .M_Reg_WE(M_Reg_WE), .M_Reg_WA(M_Reg_WA),
        .E_MD_Start(E_MD_Start), .E_MD_Div(E_MD_Div),
        .PC_WE(PC_WE), .D_WE(D_WE), .E_Clr(E_Clr), .MD_Busy(MD_Busy),
        .Stall_Cnt(Stall_Cnt)
    );

    // 10 ns clock with the first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A producer blocks a source when it writes that register and the result
    // arrives later than the consumer needs it.
    function automatic bit blocks(input int addr, input int tuse, input bit we, input int wa, input int tnew);
        return we && (addr != 0) && (wa == addr) && (tuse < tnew);
    endfunction

    function automatic bit modelBusy();
        return (rst_n == 1'b1) && (E_MD_Start || mdRemaining > 0);
    endfunction

    function automatic bit modelStall();
        bit dataHaz;
        dataHaz = blocks(D_RS_Addr, D_Tuse_RS, E_Reg_WE, E_Reg_WA, E_Tnew)
               || blocks(D_RT_Addr, D_Tuse_RT, E_Reg_WE, E_Reg_WA, E_Tnew)
               || blocks(D_RS_Addr, D_Tuse_RS, M_Reg_WE, M_Reg_WA, M_Tnew)
               || blocks(D_RT_Addr, D_Tuse_RT, M_Reg_WE, M_Reg_WA, M_Tnew);
        return dataHaz || (D_MD_Use && modelBusy());
    endfunction

    task automatic clearInputs();
        D_RS_Addr = 0; D_RT_Addr = 0; D_Tuse_RS = 2'd3; D_Tuse_RT = 2'd3;
        D_MD_Use = 0; E_Tnew = 0; E_Reg_WE = 0; E_Reg_WA = 0;
        M_Tnew = 0; M_Reg_WE = 0; M_Reg_WA = 0; E_MD_Start = 0; E_MD_Div = 0;
    endtask

    // Random traffic uses small register indices so that address matches,
    // including matches on $0, happen often.
    task automatic applyStimulus();
        D_RS_Addr  = 5'($urandom_range(0, 3));
        D_RT_Addr  = 5'($urandom_range(0, 3));
        D_Tuse_RS  = 2'($urandom_range(0, 3));
        D_Tuse_RT  = 2'($urandom_range(0, 3));
        D_MD_Use   = 1'($urandom_range(0, 1));
        E_Tnew     = 2'($urandom_range(0, 2));
        E_Reg_WE   = 1'($urandom_range(0, 1));
        E_Reg_WA   = 5'($urandom_range(0, 3));
        M_Tnew     = 2'($urandom_range(0, 2));
        M_Reg_WE   = 1'($urandom_range(0, 1));
        M_Reg_WA   = 5'($urandom_range(0, 3));
        E_MD_Start = ($urandom_range(0, 9) == 0);
        E_MD_Div   = 1'($urandom_range(0, 1));
    endtask

    // Compares every output against the model for the current inputs.
    task automatic checkAll(input string tag);
        bit st;
        st = (rst_n == 1'b1) ? modelStall() : 1'b1;
        lastStall = st;
        checkOutput({tag, ".PC_WE"},   {31'd0, PC_WE},   {31'd0, (rst_n == 1'b1) && !st});
        checkOutput({tag, ".D_WE"},    {31'd0, D_WE},    {31'd0, (rst_n == 1'b1) && !st});
        checkOutput({tag, ".E_Clr"},   {31'd0, E_Clr},   {31'd0, st});
        checkOutput({tag, ".MD_Busy"}, {31'd0, MD_Busy}, {31'd0, modelBusy()});
`ifdef HSC_STALL_CNT_EN
        checkOutput({tag, ".Stall_Cnt"}, Stall_Cnt, stallTotal);
`else
        checkOutput({tag, ".Stall_Cnt"}, Stall_Cnt, 32'd0);
`endif
    endtask

    // Checks outputs at the falling edge, advances the model at the rising
    // edge, and then drives new inputs 1 ns later.
    task automatic stepCycle(input string tag);
        @(negedge clk);
        checkAll(tag);
        @(posedge clk);
        if (rst_n) begin
            if (lastStall) stallTotal = stallTotal + 32'd1;
            if (E_MD_Start) mdRemaining = E_MD_Div ? 10 : 5;
            else if (mdRemaining > 0) mdRemaining--;
        end
        #1;
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        #2;
        checkAll("reset");
        checkOutput("reset.MD_Busy_start", {31'd0, MD_Busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use on rs from E, held for four cycles.
        E_Reg_WE = 1; E_Reg_WA = 5; E_Tnew = 2; D_RS_Addr = 5; D_Tuse_RS = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("loaduse.PC_WE", {31'd0, PC_WE}, 32'd0);
            checkOutput("loaduse.E_Clr", {31'd0, E_Clr}, 32'd1);
            #0;
            mdRemaining = mdRemaining;
            @(posedge clk);
            stallTotal = stallTotal + 32'd1;
            #1;
        end
        clearInputs();
        @(negedge clk);
        checkAll("after_loaduse");
`ifdef HSC_STALL_CNT_EN
        checkOutput("stallcnt.four", Stall_Cnt, 32'd4);
`endif
        @(posedge clk);
        #1;

        // A destination of $0 never stalls.
        E_Reg_WE = 1; E_Reg_WA = 0; E_Tnew = 2; D_RS_Addr = 0; D_Tuse_RS = 0;
        #1;
        checkOutput("zero_reg.PC_WE", {31'd0, PC_WE}, 32'd1);
        // A Tuse equal to Tnew is forwarded, so it does not stall.
        E_Reg_WA = 5; E_Tnew = 1; D_RS_Addr = 5; D_Tuse_RS = 1;
        #1;
        checkOutput("fwd_equal.PC_WE", {31'd0, PC_WE}, 32'd1);
        // An M producer that is not ready yet stalls.
        clearInputs();
        M_Reg_WE = 1; M_Reg_WA = 5; M_Tnew = 1; D_RS_Addr = 5; D_Tuse_RS = 0;
        #1;
        checkOutput("m_haz.E_Clr", {31'd0, E_Clr}, 32'd1);
        // The same check on rt, with Tuse = 3 (not used) never stalling.
        clearInputs();
        E_Reg_WE = 1; E_Reg_WA = 7; E_Tnew = 2; D_RT_Addr = 7; D_Tuse_RT = 3;
        #1;
        checkOutput("tuse3.D_WE", {31'd0, D_WE}, 32'd1);
        clearInputs();
        stepCycle("idle");

        // A mult keeps the unit busy and stalls a HI/LO user for 6 cycles.
        E_MD_Start = 1; E_MD_Div = 0; D_MD_Use = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput("mult.MD_Busy", {31'd0, MD_Busy}, (k < 6) ? 32'd1 : 32'd0);
            checkOutput("mult.E_Clr",   {31'd0, E_Clr},   (k < 6) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            E_MD_Start = 0;
        end
        mdRemaining = 0;
        stallTotal  = stallTotal + 32'd6;
        clearInputs();

        // A div is busy for 11 cycles, but without a HI/LO user it does not stall.
        E_MD_Start = 1; E_MD_Div = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("div.MD_Busy", {31'd0, MD_Busy}, (k < 11) ? 32'd1 : 32'd0);
            checkOutput("div.PC_WE",   {31'd0, PC_WE},   32'd1);
            @(posedge clk);
            #1;
            E_MD_Start = 0;
        end
        clearInputs();

        // Reset in the middle of a div aborts the operation immediately.
        E_MD_Start = 1; E_MD_Div = 1;
        stepCycle("div2.start");
        E_MD_Start = 0;
        stepCycle("div2.busy1");
        stepCycle("div2.busy2");
        rst_n = 1'b0;
        #1;
        mdRemaining = 0;
        stallTotal  = 32'd0;
        checkOutput("midreset.MD_Busy", {31'd0, MD_Busy}, 32'd0);
        checkOutput("midreset.E_Clr",   {31'd0, E_Clr},   32'd1);
        checkOutput("midreset.PC_WE",   {31'd0, PC_WE},   32'd0);
        checkOutput("midreset.Stall_Cnt", Stall_Cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        D_MD_Use = 1;
        stepCycle("postreset");
        checkOutput("postreset.PC_WE", {31'd0, PC_WE}, 32'd1);
        clearInputs();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            stepCycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
